// File: rtl/ct_mmu_iutlb_refill_ctrl.sv
// ct_mmu_iutlb_refill_ctrl: 32-entry instruction uTLB storage, lookup and miss refill sequencing
module ct_mmu_iutlb_refill_ctrl #(
   parameter int VPN_W = 27,
   parameter int PPN_W = 28,
   parameter int ENTRY = 32
) (
   input  logic             forever_cpuclk,
   input  logic             cpurst,
   input  logic             ifu_lkup_vld,
   input  logic [VPN_W-1:0] ifu_lkup_vpn,
   output logic             iutlb_busy,
   output logic             iutlb_lkup_hit,
   output logic             iutlb_lkup_miss,
   output logic [PPN_W-1:0] iutlb_lkup_ppn,
   output logic             iutlb_jtlb_req,
   output logic [VPN_W-1:0] iutlb_jtlb_vpn,
   input  logic             jtlb_iutlb_ack,
   input  logic             jtlb_iutlb_resp_vld,
   input  logic [PPN_W-1:0] jtlb_iutlb_resp_ppn,
   input  logic             jtlb_iutlb_resp_fault,
   output logic             iutlb_refill_fault,
   input  logic             iutlb_flush,
   input  logic [31:0]      plru_iutlb_ref_num,
   output logic [31:0]      utlb_plru_read_hit,
   output logic             utlb_plru_read_hit_vld,
   output logic             utlb_plru_refill_on,
   output logic             utlb_plru_refill_vld,
   output logic [31:0]      entry_vld
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE} state_t;
   localparam logic [ENTRY-1:0] ONE = 1;
   state_t state, state_nxt;
   logic [VPN_W-1:0] vpn_arr [ENTRY];
   logic [PPN_W-1:0] ppn_arr [ENTRY];
   logic [ENTRY-1:0] match, match_oh, invalid, ref_oh, victim_oh;
   logic [PPN_W-1:0] match_ppn, resp_ppn_q;
   logic             match_any, lkup_acc, lkup_hit_nxt, lkup_miss_nxt, do_write, resp_ok;
   assign match_oh      = match & (~match + ONE);
   assign match_any     = |match;
   assign lkup_acc      = ifu_lkup_vld & (state == S_IDLE) & ~iutlb_flush;
   assign lkup_hit_nxt  = lkup_acc & match_any;
   assign lkup_miss_nxt = lkup_acc & ~match_any;
   assign do_write      = (state == S_WRITE) & ~iutlb_flush & ~cpurst;
   assign resp_ok       = (state == S_WAIT) & jtlb_iutlb_resp_vld & ~jtlb_iutlb_resp_fault;
   assign invalid       = ~entry_vld;
   assign ref_oh        = (plru_iutlb_ref_num == '0) ? ONE : plru_iutlb_ref_num & (~plru_iutlb_ref_num + ONE);
   assign victim_oh     = (|invalid) ? invalid & (~invalid + ONE) : ref_oh;
   // Parallel compare of the fetch VPN against every valid entry, and PPN select of the lowest match
   always_comb begin
      match     = '0;
      match_ppn = '0;
      for (int i = 0; i < ENTRY; i++) begin
         match[i]  = entry_vld[i] && (vpn_arr[i] == ifu_lkup_vpn);
      end
      for (int i = 0; i < ENTRY; i++) begin
         match_ppn = match_ppn | (match_oh[i] ? ppn_arr[i] : '0);
      end
   end
   // State register
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) state <= S_IDLE;
      else        state <= state_nxt;
   end
   // Next-state logic; flush returns to IDLE from anywhere
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  state_nxt = lkup_miss_nxt ? S_REQ : S_IDLE;
         S_REQ:   state_nxt = jtlb_iutlb_ack ? S_WAIT : S_REQ;
         S_WAIT:  state_nxt = !jtlb_iutlb_resp_vld ? S_WAIT : jtlb_iutlb_resp_fault ? S_IDLE : S_WRITE;
         S_WRITE: state_nxt = S_IDLE;
      endcase
      if (iutlb_flush) state_nxt = S_IDLE;
   end
   // State-decoded outputs; the write strobe is suppressed when the write itself is cancelled
   always_comb begin
      iutlb_busy           = state != S_IDLE;
      iutlb_jtlb_req       = state == S_REQ;
      utlb_plru_refill_on  = state != S_IDLE;
      utlb_plru_refill_vld = do_write;
   end
   // Registered lookup results, miss VPN and response capture, fault pulse and valid bits
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         iutlb_lkup_hit         <= 1'b0;
         iutlb_lkup_miss        <= 1'b0;
         iutlb_lkup_ppn         <= '0;
         utlb_plru_read_hit     <= '0;
         utlb_plru_read_hit_vld <= 1'b0;
         iutlb_jtlb_vpn         <= '0;
         iutlb_refill_fault     <= 1'b0;
         resp_ppn_q             <= '0;
         entry_vld              <= '0;
      end else begin
         iutlb_lkup_hit         <= lkup_hit_nxt;
         iutlb_lkup_miss        <= lkup_miss_nxt;
         iutlb_lkup_ppn         <= lkup_hit_nxt ? match_ppn : '0;
         utlb_plru_read_hit     <= lkup_hit_nxt ? match_oh : '0;
         utlb_plru_read_hit_vld <= lkup_hit_nxt;
         iutlb_jtlb_vpn         <= lkup_miss_nxt ? ifu_lkup_vpn : iutlb_jtlb_vpn;
         iutlb_refill_fault     <= (state == S_WAIT) & jtlb_iutlb_resp_vld & jtlb_iutlb_resp_fault & ~iutlb_flush;
         resp_ppn_q             <= resp_ok ? jtlb_iutlb_resp_ppn : resp_ppn_q;
         entry_vld              <= iutlb_flush ? '0 : do_write ? entry_vld | victim_oh : entry_vld;
      end
   end
   // Entry payload storage, written into the chosen victim slot
   always_ff @(posedge forever_cpuclk) begin
      for (int i = 0; i < ENTRY; i++) begin
         if (do_write && victim_oh[i]) begin
            vpn_arr[i] <= iutlb_jtlb_vpn;
            ppn_arr[i] <= resp_ppn_q;
         end
      end
   end
endmodule
